// File: rtl/tlk2711_tx_sched.sv
// Transmit scheduler for a shared TLK2711 serializer port: round-robin arbitration
// between frame sources, comma/SOF/EOF framing, and idle fill between frames.
module tlk2711_tx_sched #(
    parameter int NUM_REQ = 2,
    parameter int LEN_W   = 16
) (
    input  logic                     tx_clk,
    input  logic                     rst,
    input  logic                     i_enable,
    input  logic [NUM_REQ-1:0]       i_req,
    input  logic [NUM_REQ*LEN_W-1:0] i_len,
    input  logic [NUM_REQ*16-1:0]    i_data,
    output logic [NUM_REQ-1:0]       o_rd,
    output logic [NUM_REQ-1:0]       o_grant,
    output logic                     o_busy,
    output logic                     o_frame_done,
    output logic [15:0]              o_txd,
    output logic                     o_tkmsb,
    output logic                     o_tklsb
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [15:0] W_IDLE = 16'hBCC5;
    localparam logic [15:0] W_SOF  = 16'hBCAB;
    localparam logic [15:0] W_EOF  = 16'hBC95;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COMMA1,
        S_COMMA2,
        S_SOF,
        S_DATA,
        S_EOF
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   gnt_idx;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   cnt;
    logic               rr_found;
    logic [IDX_W-1:0]   rr_idx;
    int                 cand;
    logic [IDX_W-1:0]   cand_idx;

    // Round-robin search starting one past the last winner, wrapping modulo NUM_REQ.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(last) + i;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            cand_idx = IDX_W'(cand);
            if (!rr_found && i_req[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    always_ff @(posedge tx_clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            last    <= IDX_W'(NUM_REQ - 1);
            gnt_idx <= '0;
            o_grant <= '0;
            len_q   <= '0;
            cnt     <= '0;
            o_txd   <= 16'h0000;
            o_tkmsb <= 1'b0;
            o_tklsb <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    o_txd   <= W_IDLE;
                    o_tkmsb <= 1'b1;
                    o_tklsb <= 1'b0;
                    if (i_enable && rr_found) begin
                        gnt_idx <= rr_idx;
                        o_grant <= NUM_REQ'(1) << rr_idx;
                        last    <= rr_idx;
                        len_q   <= i_len[rr_idx*LEN_W +: LEN_W];
                        state   <= S_COMMA1;
                    end
                end
                S_COMMA1: begin
                    o_txd   <= W_IDLE;
                    o_tkmsb <= 1'b1;
                    o_tklsb <= 1'b0;
                    state   <= S_COMMA2;
                end
                S_COMMA2: begin
                    o_txd   <= W_IDLE;
                    o_tkmsb <= 1'b1;
                    o_tklsb <= 1'b0;
                    state   <= S_SOF;
                end
                S_SOF: begin
                    o_txd   <= W_SOF;
                    o_tkmsb <= 1'b1;
                    o_tklsb <= 1'b0;
                    cnt     <= '0;
                    state   <= (len_q == '0) ? S_EOF : S_DATA;
                end
                S_DATA: begin
                    // len_q is nonzero here, so len_q-1 cannot underflow.
                    o_txd   <= i_data[gnt_idx*16 +: 16];
                    o_tkmsb <= 1'b0;
                    o_tklsb <= 1'b0;
                    cnt     <= cnt + LEN_W'(1);
                    if (cnt == len_q - LEN_W'(1)) state <= S_EOF;
                end
                S_EOF: begin
                    o_txd   <= W_EOF;
                    o_tkmsb <= 1'b1;
                    o_tklsb <= 1'b0;
                    o_grant <= '0;
                    state   <= S_IDLE;
                end
                default: begin
                    o_grant <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rd         = (state == S_DATA) ? o_grant : '0;
    assign o_busy       = (state != S_IDLE);
    assign o_frame_done = (state == S_EOF);

endmodule

// File: doc/tlk2711_tx_sched.md
# tlk2711_tx_sched

Transmit-side scheduler that shares one TLK2711 serializer transmit port between `NUM_REQ` frame sources. It runs round-robin arbitration and wraps each granted payload in comma/SOF/EOF control words. It fills every non-frame cycle with K28.5/D5.6 idle words. It sits between the packet sources and the TLK2711 pin driver, and owns `o_txd`, `o_tkmsb` and `o_tklsb`.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters (2..8).
- `LEN_W`, default 16: width of the frame payload length in 16-bit words.

Ports:
- `tx_clk`  in  1  sole clock.
- `rst`  in  1  asynchronous, active-high reset.
- `i_enable`  in  1  permits new frames to start; a frame in flight always completes.
- `i_req`  in  NUM_REQ  per-requester frame request level.
- `i_len`  in  NUM_REQ*LEN_W  per-requester payload length; slice k = `[k*LEN_W +: LEN_W]`.
- `i_data`  in  NUM_REQ*16  per-requester first-word-fall-through payload word; slice k = `[k*16 +: 16]`.
- `o_rd`  out  NUM_REQ  one-hot pop strobe; the presented word is consumed in that cycle.
- `o_grant`  out  NUM_REQ  one-hot, registered; held from COMMA1 through EOF.
- `o_busy`  out  1  high while the state is not IDLE.
- `o_frame_done`  out  1  one-cycle pulse in the EOF state cycle.
- `o_txd`  out  16  TLK2711 TXD.
- `o_tkmsb`  out  1  K flag for `o_txd[15:8]`.
- `o_tklsb`  out  1  K flag for `o_txd[7:0]`.

## Operation
Code words:
- IDLE/COMMA: `{K28.5=8'hBC, D5.6=8'hC5}`, tkmsb=1, tklsb=0.
- SOF: `{8'hBC, D11.5=8'hAB}`, tkmsb=1, tklsb=0.
- EOF: `{8'hBC, D21.4=8'h95}`, tkmsb=1, tklsb=0.
- DATA: `i_data` slice of the granted requester, tkmsb=tklsb=0.

State machine: IDLE → COMMA1 → COMMA2 → SOF → DATA → EOF → IDLE.
- IDLE:
  - Emits the idle word.
  - If `i_enable` and `|i_req`, selects the winner by round-robin: search starts at `last+1` modulo NUM_REQ.
  - Latches the winner's `i_len` into `len_q`, sets `o_grant`, updates `last`, then goes to COMMA1.
- COMMA1 and COMMA2: each emits the comma word.
- SOF: emits SOF, clears the `LEN_W`-bit data counter, then goes to DATA. If `len_q==0` it skips DATA and goes directly to EOF.
- DATA:
  - `o_rd[grant]=1` combinationally every cycle.
  - The counter increments each cycle; the state leaves for EOF when `cnt==len_q-1`.
  - Exactly `len_q` words are popped.
- EOF: emits EOF, pulses `o_frame_done`, clears `o_grant`, then returns to IDLE.

The mandatory IDLE cycle guarantees at least one idle word between frames.

Rules:
- `i_req` is sampled only in IDLE. Dropping `i_req` mid-frame does not abort the frame; the source must keep supplying data.
- `i_len` changes after the grant are ignored.
- `i_enable` low blocks only the IDLE→COMMA1 transition.
- An X or illegal `o_grant` is impossible: `o_grant` is always one-hot or zero.

## Timing
- Output words are registered. `o_txd`, `o_tkmsb` and `o_tklsb` at cycle t+1 reflect the state at cycle t.
- Data popped with `o_rd` at cycle t appears on `o_txd` at t+1.
- Latency: request seen in IDLE at cycle t → `o_grant` high at t+1 → first comma on `o_txd` at t+2 → first data word at t+5.
- Frame occupancy is `len+4` state cycles plus 1 IDLE cycle.
- The round-robin pointer `last` updates only on grant.
- With all requesters continuously asserting, grants rotate 0,1,…,NUM_REQ-1,0,…
- Reset (asynchronous, any state, including mid-frame):
  - State = IDLE; `last = NUM_REQ-1`, so requester 0 wins first.
  - `o_grant=0`, `o_rd=0`, `o_busy=0`, `o_frame_done=0`.
  - `o_txd=16'h0000`, `o_tkmsb=0`, `o_tklsb=0`.
  - The first clock after reset release loads the idle word.
- Counter arithmetic is unsigned `LEN_W` bits. The maximum length `2^LEN_W-1` must complete without wrap.

## Test plan
- Single request: `i_req=2'b01`, `len=3`, data 16'h1111/2222/3333 → `o_txd` sequence BCC5, BCC5, BCAB, 1111, 2222, 3333, BC95, then BCC5.
  - Expected flags: tkmsb 1,1,1,0,0,0,1; `o_rd[0]` high for exactly 3 cycles; one `o_frame_done` pulse.
- Round-robin: `i_req=2'b11` held, `len=2` each → grants alternate 01,10,01,10. Each pair of frames is separated by at least one BCC5 word.
- Zero length: `len=0` → BCC5, BCC5, BCAB, BC95; `o_rd` never asserted.
- Enable gating: `i_enable=0` with `i_req=2'b10` → idle words only and `o_busy=0`. Deasserting `i_enable` during DATA still completes the frame through EOF.
- Reset mid-frame: assert `rst` during the DATA of a `len=8` frame → all outputs 0 immediately with no clock. After release, `o_txd=BCC5`, and the next grant goes to requester 0.
